// File: rtl/chacha20_pkg.sv
// Shared ChaCha20 definitions.
// Holds the sigma constants, state geometry, the block-sequencer FSM
// encoding, and helpers that build the initial 16-word state and perform
// the per-word mod-2^32 feed-forward addition.
package chacha20_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned NUM_WORDS = 16;
  localparam int unsigned STATE_W   = WORD_W * NUM_WORDS;

  localparam logic [31:0] SIGMA0 = 32'h61707865;
  localparam logic [31:0] SIGMA1 = 32'h3320646e;
  localparam logic [31:0] SIGMA2 = 32'h79622d32;
  localparam logic [31:0] SIGMA3 = 32'h6b206574;

  // Bit offset of the block counter (word 12) inside the packed state.
  localparam int unsigned CTR_LSB = 12 * WORD_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROUND  = 2'd1,
    ST_OUTPUT = 2'd2
  } seq_state_e;

  // Word i of the result occupies bits [32i+31:32i].
  function automatic logic [STATE_W-1:0] build_init_state(
    input logic [255:0] key,
    input logic [95:0]  nonce,
    input logic [31:0]  counter
  );
    logic [STATE_W-1:0] s;
    s = {nonce, counter, key, SIGMA3, SIGMA2, SIGMA1, SIGMA0};
    return s;
  endfunction

  function automatic logic [STATE_W-1:0] add_state(
    input logic [STATE_W-1:0] a,
    input logic [STATE_W-1:0] b
  );
    logic [STATE_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
      r[WORD_W*i +: WORD_W] = a[WORD_W*i +: WORD_W] + b[WORD_W*i +: WORD_W];
    end
    return r;
  endfunction

endpackage

// File: rtl/chacha20_column_and_diagonal_round.sv
// One ChaCha20 double round, purely combinational.
// Ports:
//   state_i  512  input state, word i = bits [32i+31:32i]
//   state_o  512  state after a column round followed by a diagonal round
module chacha20_column_and_diagonal_round
  import chacha20_pkg::*;
(
  input  logic [STATE_W-1:0] state_i,
  output logic [STATE_W-1:0] state_o
);

  // Packed quarter-round operand: a=[31:0] b=[63:32] c=[95:64] d=[127:96].
  function automatic logic [127:0] quarter_round(input logic [127:0] abcd);
    logic [31:0] a, b, c, d;
    a = abcd[31:0];
    b = abcd[63:32];
    c = abcd[95:64];
    d = abcd[127:96];
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {d, c, b, a};
  endfunction

  logic [31:0] in_w  [NUM_WORDS];
  logic [31:0] col_w [NUM_WORDS];
  logic [31:0] dia_w [NUM_WORDS];

  for (genvar i = 0; i < NUM_WORDS; i++) begin : g_unpack
    assign in_w[i] = state_i[WORD_W*i +: WORD_W];
    assign state_o[WORD_W*i +: WORD_W] = dia_w[i];
  end

  for (genvar q = 0; q < 4; q++) begin : g_qr
    logic [127:0] col_r;
    logic [127:0] dia_r;

    // Column q: words q, q+4, q+8, q+12.
    assign col_r = quarter_round({in_w[q+12], in_w[q+8], in_w[q+4], in_w[q]});
    assign col_w[q]    = col_r[31:0];
    assign col_w[q+4]  = col_r[63:32];
    assign col_w[q+8]  = col_r[95:64];
    assign col_w[q+12] = col_r[127:96];

    // Diagonal q: words q, 4+(q+1)%4, 8+(q+2)%4, 12+(q+3)%4.
    assign dia_r = quarter_round({col_w[12+((q+3)%4)], col_w[8+((q+2)%4)],
                                  col_w[4+((q+1)%4)],  col_w[q]});
    assign dia_w[q]              = dia_r[31:0];
    assign dia_w[4+((q+1)%4)]    = dia_r[63:32];
    assign dia_w[8+((q+2)%4)]    = dia_r[95:64];
    assign dia_w[12+((q+3)%4)]   = dia_r[127:96];
  end

endmodule

// File: rtl/chacha20_block_sequencer.sv
// Iterative ChaCha20 keystream generator using one shared double-round.
// A command (key, nonce, counter, block count) is accepted in IDLE; each
// block takes DOUBLE_ROUNDS cycles of rounds, then is presented on a
// valid/ready output with out_last flagging the final block.
// Ports:
//   clock, reset          rising-edge clock, async active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_key/nonce/counter key material and first block counter
//   cmd_num_blocks        blocks to emit, 0 treated as 1
//   out_valid/out_ready   keystream handshake
//   out_block, out_last   512-bit keystream block, final-block flag
//   busy                  high whenever not IDLE
module chacha20_block_sequencer
  import chacha20_pkg::*;
#(
  parameter int unsigned DOUBLE_ROUNDS = 10
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [255:0]   cmd_key,
  input  logic [95:0]    cmd_nonce,
  input  logic [31:0]    cmd_counter,
  input  logic [15:0]    cmd_num_blocks,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [511:0]   out_block,
  output logic           out_last,
  output logic           busy
);

  localparam logic [3:0] LAST_ROUND = 4'(DOUBLE_ROUNDS - 1);

  seq_state_e         state_q;
  logic [STATE_W-1:0] init_q;
  logic [STATE_W-1:0] work_q;
  logic [3:0]         round_cnt_q;
  logic [15:0]        blocks_left_q;
  logic [STATE_W-1:0] out_block_q;
  logic               out_last_q;
  logic               out_valid_q;
  logic               cmd_ready_q;
  logic               busy_q;

  logic [STATE_W-1:0] round_state;
  logic [31:0]        ctr_next;

  chacha20_column_and_diagonal_round u_round (
    .state_i (work_q),
    .state_o (round_state)
  );

  assign ctr_next = init_q[CTR_LSB +: WORD_W] + 32'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      init_q        <= '0;
      work_q        <= '0;
      round_cnt_q   <= '0;
      blocks_left_q <= '0;
      out_block_q   <= '0;
      out_last_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      cmd_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // cmd_ready is registered, so it first rises one edge after reset
          // release and must already be high for a command to be taken.
          if (cmd_ready_q && cmd_valid) begin
            init_q        <= build_init_state(cmd_key, cmd_nonce, cmd_counter);
            work_q        <= build_init_state(cmd_key, cmd_nonce, cmd_counter);
            round_cnt_q   <= '0;
            blocks_left_q <= (cmd_num_blocks == 16'd0) ? 16'd1 : cmd_num_blocks;
            cmd_ready_q   <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= ST_ROUND;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end

        ST_ROUND: begin
          work_q      <= round_state;
          round_cnt_q <= round_cnt_q + 4'd1;
          if (round_cnt_q == LAST_ROUND) begin
            out_block_q <= add_state(round_state, init_q);
            out_last_q  <= (blocks_left_q == 16'd1);
            out_valid_q <= 1'b1;
            state_q     <= ST_OUTPUT;
          end
        end

        ST_OUTPUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (out_last_q) begin
              out_last_q  <= 1'b0;
              cmd_ready_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= ST_IDLE;
            end else begin
              // Next block: bump the counter in both copies and restore the
              // rest of the working state from the saved initial state.
              blocks_left_q               <= blocks_left_q - 16'd1;
              init_q[CTR_LSB +: WORD_W]   <= ctr_next;
              work_q <= {init_q[STATE_W-1:CTR_LSB+WORD_W], ctr_next,
                         init_q[CTR_LSB-1:0]};
              round_cnt_q <= '0;
              state_q     <= ST_ROUND;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign out_valid = out_valid_q;
  assign out_block = out_block_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_chacha20_block_sequencer.sv
module tb_chacha20_block_sequencer;

  localparam int unsigned DR = 10;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [255:0] cmd_key = '0;
  logic [95:0]  cmd_nonce = '0;
  logic [31:0]  cmd_counter = '0;
  logic [15:0]  cmd_num_blocks = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [511:0] out_block;
  logic         out_last;
  logic         busy;

  int total = 0;
  int bad   = 0;

  chacha20_block_sequencer #(.DOUBLE_ROUNDS(DR)) dut (
    .clock          (clock),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_key        (cmd_key),
    .cmd_nonce      (cmd_nonce),
    .cmd_counter    (cmd_counter),
    .cmd_num_blocks (cmd_num_blocks),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_block      (out_block),
    .out_last       (out_last),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] v, input int r);
    return (v << r) | (v >> (32 - r));
  endfunction

  // Reference block function straight from the ChaCha20 definition.
  function automatic logic [511:0] ref_block(input logic [255:0] key,
                                             input logic [95:0] nonce,
                                             input logic [31:0] ctr);
    logic [31:0] s [16];
    logic [31:0] x [16];
    logic [511:0] o;
    int a, b, c, d, q;
    s[0] = 32'h61707865; s[1] = 32'h3320646e;
    s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int k = 0; k < 8; k++) s[4+k] = key[32*k +: 32];
    s[12] = ctr;
    for (int n = 0; n < 3; n++) s[13+n] = nonce[32*n +: 32];
    x = s;
    for (int r = 0; r < int'(DR); r++) begin
      for (int p = 0; p < 8; p++) begin
        q = p % 4;
        a = q;
        if (p < 4) begin
          b = q + 4; c = q + 8; d = q + 12;
        end else begin
          b = 4 + (q + 1) % 4; c = 8 + (q + 2) % 4; d = 12 + (q + 3) % 4;
        end
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 16);
        x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 12);
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 8);
        x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 7);
      end
    end
    for (int i = 0; i < 16; i++) o[32*i +: 32] = x[i] + s[i];
    return o;
  endfunction

  typedef struct {
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  ctr;
    logic [15:0]  nb;
    bit           rnd;
    bit           has_kat;
    logic [31:0]  kat_w0;
    logic [31:0]  kat_w15;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  logic [255:0] rfc_key;
  logic [95:0]  rfc_nonce;

  task automatic wait_cmd_ready();
    int to = 0;
    while (!cmd_ready && to < 200) begin
      @(negedge clock);
      to++;
    end
    check("cmd_ready_wait", 512'(cmd_ready), 512'(1));
  endtask

  // Issue a command and consume all of its blocks, checking content,
  // out_last, latency (fixed-ready mode) and hold-while-stalled (random mode).
  task automatic run_cmd(input vec_t v, input string tag);
    int eff, n, k;
    bit hold_ok;
    logic [511:0] blk, exp;
    eff = (v.nb == 16'd0) ? 1 : int'(v.nb);
    out_ready = v.rnd ? 1'b0 : 1'b1;
    wait_cmd_ready();
    cmd_key = v.key; cmd_nonce = v.nonce; cmd_counter = v.ctr;
    cmd_num_blocks = v.nb; cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    n = 0;
    for (int b = 0; b < eff; b++) begin
      while (!out_valid && n < 100) begin
        @(negedge clock);
        n++;
      end
      check({tag, "_valid"}, 512'(out_valid), 512'(1));
      if (!out_valid) return;
      if (!v.rnd) check({tag, "_latency"}, 512'(n), 512'(DR));
      exp = ref_block(v.key, v.nonce, v.ctr + 32'(b));
      check({tag, "_block"}, out_block, exp);
      check({tag, "_last"}, 512'(out_last), 512'(b == eff - 1));
      if (b == 0 && v.has_kat) begin
        check({tag, "_kat_w0"}, 512'(out_block[31:0]), 512'(v.kat_w0));
        check({tag, "_kat_w15"}, 512'(out_block[511:480]), 512'(v.kat_w15));
      end
      if (v.rnd) begin
        blk = out_block;
        hold_ok = 1'b1;
        k = $urandom_range(0, 3);
        repeat (k) begin
          @(negedge clock);
          if (out_block !== blk || out_valid !== 1'b1) hold_ok = 1'b0;
        end
        check({tag, "_hold"}, 512'(hold_ok), 512'(1));
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
      end else begin
        @(negedge clock);
      end
      n = 0;
    end
    check({tag, "_idle_busy"}, 512'(busy), 512'(0));
    check({tag, "_idle_ready"}, 512'(cmd_ready), 512'(1));
  endtask

  initial begin
    vec_t v;
    bit ok;
    int blocks, lasts;
    logic [511:0] blk;

    for (int i = 0; i < 32; i++) rfc_key[8*i +: 8] = 8'(i);
    rfc_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};

    vecs[0] = '{rfc_key, rfc_nonce, 32'd1, 16'd1, 1'b0, 1'b1, 32'he4e7f110, 32'h4e3c50a2};
    vecs[1] = '{rfc_key, rfc_nonce, 32'd1, 16'd3, 1'b0, 1'b1, 32'he4e7f110, 32'h4e3c50a2};
    vecs[2] = '{rfc_key, rfc_nonce, 32'hffffffff, 16'd2, 1'b0, 1'b0, 32'd0, 32'd0};
    vecs[3] = '{'0, '0, 32'd0, 16'd0, 1'b0, 1'b0, 32'd0, 32'd0};
    for (int i = 4; i < NV; i++) begin
      for (int w = 0; w < 8; w++) vecs[i].key[32*w +: 32] = $urandom;
      for (int w = 0; w < 3; w++) vecs[i].nonce[32*w +: 32] = $urandom;
      vecs[i].ctr     = (i == 5) ? 32'hfffffffe : $urandom;
      vecs[i].nb      = 16'($urandom_range(1, 3));
      vecs[i].rnd     = (i % 2 == 0);
      vecs[i].has_kat = 1'b0;
      vecs[i].kat_w0  = '0;
      vecs[i].kat_w15 = '0;
    end

    // Reset values while reset is held.
    #1;
    check("rst_cmd_ready", 512'(cmd_ready), 512'(0));
    check("rst_out_valid", 512'(out_valid), 512'(0));
    check("rst_out_last", 512'(out_last), 512'(0));
    check("rst_busy", 512'(busy), 512'(0));
    check("rst_out_block", out_block, 512'(0));
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_cmd(vecs[i], $sformatf("vec%0d", i));
    end

    // Stall in OUTPUT for 20 cycles with out_ready low.
    v = vecs[0];
    out_ready = 1'b0;
    wait_cmd_ready();
    cmd_key = v.key; cmd_nonce = v.nonce; cmd_counter = v.ctr;
    cmd_num_blocks = 16'd1; cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    begin
      int n = 0;
      while (!out_valid && n < 100) begin
        @(negedge clock);
        n++;
      end
    end
    check("stall_valid", 512'(out_valid), 512'(1));
    blk = out_block;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clock);
      if (out_block !== blk || cmd_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1)
        ok = 1'b0;
    end
    check("stall_hold", 512'(ok), 512'(1));
    check("stall_block", blk, ref_block(v.key, v.nonce, v.ctr));
    out_ready = 1'b1;
    @(negedge clock);
    check("stall_release_valid", 512'(out_valid), 512'(0));
    check("stall_release_busy", 512'(busy), 512'(0));

    // num_blocks=0 with cmd_valid held high: one block, no accept while busy.
    v = vecs[6];
    wait_cmd_ready();
    cmd_key = v.key; cmd_nonce = v.nonce; cmd_counter = v.ctr;
    cmd_num_blocks = 16'd0; cmd_valid = 1'b1; out_ready = 1'b1;
    @(negedge clock);
    ok = 1'b1; blocks = 0; lasts = 0;
    begin
      int n = 0;
      while (busy && n < 100) begin
        if (cmd_ready) ok = 1'b0;
        if (out_valid) begin
          blocks++;
          if (out_last) lasts++;
          blk = out_block;
        end
        @(negedge clock);
        n++;
      end
    end
    cmd_valid = 1'b0;
    check("nb0_no_accept_busy", 512'(ok), 512'(1));
    check("nb0_blocks", 512'(blocks), 512'(1));
    check("nb0_last", 512'(lasts), 512'(1));
    check("nb0_block", blk, ref_block(v.key, v.nonce, v.ctr));
    check("nb0_idle", 512'(busy), 512'(0));

    // Reset pulsed during round 5.
    v = vecs[0];
    wait_cmd_ready();
    cmd_key = v.key; cmd_nonce = v.nonce; cmd_counter = v.ctr;
    cmd_num_blocks = 16'd1; cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clock);
    check("pre_rst_busy", 512'(busy), 512'(1));
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", 512'(busy), 512'(0));
    check("mid_rst_cmd_ready", 512'(cmd_ready), 512'(0));
    check("mid_rst_out_valid", 512'(out_valid), 512'(0));
    check("mid_rst_out_last", 512'(out_last), 512'(0));
    check("mid_rst_out_block", out_block, 512'(0));
    @(negedge clock);
    reset = 1'b0;
    run_cmd(vecs[0], "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
